// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NREGS word registers as a flat vector, with
// independent read/write FSMs and a one-cycle write-strobe per register.
module axi_lite_slave_regs #(
  parameter int ASIZE = 32,
  parameter int DSIZE = 32,
  parameter int NREGS = 8
) (
  input  logic                   axi_lite_aclk,
  input  logic                   axi_lite_reset,
  input  logic                   axi_lite_awvalid,
  output logic                   axi_lite_awready,
  input  logic [ASIZE-1:0]       axi_lite_awaddr,
  input  logic                   axi_lite_wvalid,
  output logic                   axi_lite_wready,
  input  logic [DSIZE-1:0]       axi_lite_wdata,
  output logic                   axi_lite_bvalid,
  input  logic                   axi_lite_bready,
  output logic [1:0]             axi_lite_bresp,
  input  logic                   axi_lite_arvalid,
  output logic                   axi_lite_arready,
  input  logic [ASIZE-1:0]       axi_lite_araddr,
  output logic                   axi_lite_rvalid,
  input  logic                   axi_lite_rready,
  output logic [DSIZE-1:0]       axi_lite_rdata,
  output logic [1:0]             axi_lite_rresp,
  output logic [NREGS*DSIZE-1:0] reg_q,
  output logic [NREGS-1:0]       reg_wr_pulse
);

  localparam int IDX_W = $clog2(NREGS);

  typedef enum logic [1:0] {W_IDLE, W_GOT_A, W_GOT_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t         w_state_reg;
  r_state_t         r_state_reg;
  logic [ASIZE-1:0] awaddr_reg;
  logic [DSIZE-1:0] wdata_reg;
  logic [DSIZE-1:0] regs_reg [NREGS];
  logic             bvalid_reg;
  logic [1:0]       bresp_reg;
  logic [NREGS-1:0] wr_pulse_reg;
  logic             rvalid_reg;
  logic [1:0]       rresp_reg;
  logic [DSIZE-1:0] rdata_reg;

  logic             aw_hs, w_hs, ar_hs;
  logic             wr_fire;
  logic [ASIZE-1:0] wr_addr;
  logic [DSIZE-1:0] wr_data;
  logic             wr_ok;
  logic [IDX_W-1:0] wr_idx;

  // Any address bit above the register window makes the access out of range.
  function automatic logic in_range(input logic [ASIZE-1:0] addr);
    return (addr >> (IDX_W + 2)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ASIZE-1:0] addr);
    return IDX_W'(addr >> 2);
  endfunction

  assign axi_lite_awready = !axi_lite_reset && (w_state_reg == W_IDLE || w_state_reg == W_GOT_D);
  assign axi_lite_wready  = !axi_lite_reset && (w_state_reg == W_IDLE || w_state_reg == W_GOT_A);
  assign axi_lite_arready = !axi_lite_reset && (r_state_reg == R_IDLE);

  assign aw_hs = axi_lite_awvalid && axi_lite_awready;
  assign w_hs  = axi_lite_wvalid  && axi_lite_wready;
  assign ar_hs = axi_lite_arvalid && axi_lite_arready;

  // Select address/data of the handshake that completes the write this cycle.
  always_comb begin
    wr_fire = 1'b0;
    wr_addr = awaddr_reg;
    wr_data = wdata_reg;
    case (w_state_reg)
      W_IDLE: if (aw_hs && w_hs) begin
        wr_fire = 1'b1;
        wr_addr = axi_lite_awaddr;
        wr_data = axi_lite_wdata;
      end
      W_GOT_A: if (w_hs) begin
        wr_fire = 1'b1;
        wr_data = axi_lite_wdata;
      end
      W_GOT_D: if (aw_hs) begin
        wr_fire = 1'b1;
        wr_addr = axi_lite_awaddr;
      end
      default: ;
    endcase
  end

  assign wr_ok  = in_range(wr_addr);
  assign wr_idx = addr_index(wr_addr);

  always_ff @(posedge axi_lite_aclk) begin
    if (axi_lite_reset) begin
      w_state_reg  <= W_IDLE;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= 2'b00;
      wr_pulse_reg <= '0;
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else begin
      wr_pulse_reg <= '0;
      if (wr_fire) begin
        bvalid_reg  <= 1'b1;
        bresp_reg   <= wr_ok ? 2'b00 : 2'b10;
        w_state_reg <= W_RESP;
        if (wr_ok) begin
          regs_reg[wr_idx]     <= wr_data;
          wr_pulse_reg[wr_idx] <= 1'b1;
        end
      end else begin
        case (w_state_reg)
          W_IDLE: begin
            if (aw_hs) begin
              awaddr_reg  <= axi_lite_awaddr;
              w_state_reg <= W_GOT_A;
            end else if (w_hs) begin
              wdata_reg   <= axi_lite_wdata;
              w_state_reg <= W_GOT_D;
            end
          end
          W_RESP: if (axi_lite_bready) begin
            bvalid_reg  <= 1'b0;
            w_state_reg <= W_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Reads sample the register array before any same-edge write lands.
  always_ff @(posedge axi_lite_aclk) begin
    if (axi_lite_reset) begin
      r_state_reg <= R_IDLE;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= 2'b00;
      rdata_reg   <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: if (ar_hs) begin
          rvalid_reg  <= 1'b1;
          r_state_reg <= R_DATA;
          if (in_range(axi_lite_araddr)) begin
            rdata_reg <= regs_reg[addr_index(axi_lite_araddr)];
            rresp_reg <= 2'b00;
          end else begin
            rdata_reg <= '0;
            rresp_reg <= 2'b10;
          end
        end
        R_DATA: if (axi_lite_rready) begin
          rvalid_reg  <= 1'b0;
          r_state_reg <= R_IDLE;
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pack
    assign reg_q[gi*DSIZE +: DSIZE] = regs_reg[gi];
  end

  assign axi_lite_bvalid = bvalid_reg;
  assign axi_lite_bresp  = bresp_reg;
  assign axi_lite_rvalid = rvalid_reg;
  assign axi_lite_rresp  = rresp_reg;
  assign axi_lite_rdata  = rdata_reg;
  assign reg_wr_pulse    = wr_pulse_reg;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: table of single transactions plus
// hand-written sequences for split writes, collisions, backpressure and reset.
module tb_axi_lite_slave_regs;

  localparam int ASIZE = 32;
  localparam int DSIZE = 32;
  localparam int NREGS = 8;

  logic clk = 1'b0;
  logic rst;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [ASIZE-1:0] awaddr, araddr;
  logic [DSIZE-1:0] wdata, rdata;
  logic [1:0] bresp, rresp;
  logic [NREGS*DSIZE-1:0] reg_q;
  logic [NREGS-1:0] reg_wr_pulse;

  always #5 clk = ~clk;

  axi_lite_slave_regs #(.ASIZE(ASIZE), .DSIZE(DSIZE), .NREGS(NREGS)) dut (
    .axi_lite_aclk(clk), .axi_lite_reset(rst),
    .axi_lite_awvalid(awvalid), .axi_lite_awready(awready), .axi_lite_awaddr(awaddr),
    .axi_lite_wvalid(wvalid), .axi_lite_wready(wready), .axi_lite_wdata(wdata),
    .axi_lite_bvalid(bvalid), .axi_lite_bready(bready), .axi_lite_bresp(bresp),
    .axi_lite_arvalid(arvalid), .axi_lite_arready(arready), .axi_lite_araddr(araddr),
    .axi_lite_rvalid(rvalid), .axi_lite_rready(rready), .axi_lite_rdata(rdata),
    .axi_lite_rresp(rresp), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  exp_resp;
    logic [31:0] exp_val;  // expected pulse vector for writes, rdata for reads
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [NREGS];
  vec_t vecs [11];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < NREGS; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          output logic [1:0] resp, output logic [7:0] pulse);
    int waited = 0;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(awready && wready) && waited < 20) begin tick(); waited++; end
    chk("wr_ready_wait", 256'(waited < 20), 256'(1));
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", 256'(bvalid), 256'(1));
    resp = bresp; pulse = reg_wr_pulse;
    tick();
    chk("wr_bvalid_drop", 256'(bvalid), 256'(0));
    chk("wr_pulse_one_cycle", 256'(reg_wr_pulse), 256'(0));
    $display("[TB] write addr=%h data=%h bresp=%b pulse=%h", addr, data, resp, pulse);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [1:0] resp, output logic [31:0] data);
    int waited = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!arready && waited < 20) begin tick(); waited++; end
    chk("rd_ready_wait", 256'(waited < 20), 256'(1));
    tick();
    arvalid = 1'b0;
    chk("rd_rvalid", 256'(rvalid), 256'(1));
    resp = rresp; data = rdata;
    tick();
    chk("rd_rvalid_drop", 256'(rvalid), 256'(0));
    $display("[TB] read  addr=%h rdata=%h rresp=%b", addr, data, resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic [31:0] data;

    vecs[0]  = '{1'b1, 32'h04,       32'hDEADBEEF, 2'b00, 32'h02};
    vecs[1]  = '{1'b1, 32'h00,       32'h11111111, 2'b00, 32'h01};
    vecs[2]  = '{1'b1, 32'h1E,       32'h00000077, 2'b00, 32'h80};
    vecs[3]  = '{1'b0, 32'h04,       32'h0,        2'b00, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 32'h1F,       32'h0,        2'b00, 32'h00000077};
    vecs[5]  = '{1'b1, 32'h20,       32'hCAFEF00D, 2'b10, 32'h00};
    vecs[6]  = '{1'b0, 32'h20,       32'h0,        2'b10, 32'h0};
    vecs[7]  = '{1'b0, 32'h80000000, 32'h0,        2'b10, 32'h0};
    vecs[8]  = '{1'b1, 32'h08,       32'h0000000A, 2'b00, 32'h04};
    vecs[9]  = '{1'b0, 32'h08,       32'h0,        2'b00, 32'h0000000A};
    vecs[10] = '{1'b0, 32'h00,       32'h0,        2'b00, 32'h11111111};
    for (int i = 0; i < NREGS; i++) model[i] = '0;

    rst = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0;
    tick(); tick();
    chk("rst_readies", 256'({awready, wready, arready}), 256'(0));
    chk("rst_valids", 256'({bvalid, rvalid}), 256'(0));
    chk("rst_resps", 256'({bresp, rresp}), 256'(0));
    chk("rst_rdata", 256'(rdata), 256'(0));
    chk("rst_regs", reg_q, 256'(0));
    chk("rst_pulse", 256'(reg_wr_pulse), 256'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_readies", 256'({awready, wready, arready}), 256'(3'b111));
    tick();

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].is_wr) begin
        do_write(vecs[v].addr, vecs[v].data, resp, pulse);
        chk($sformatf("v%0d_bresp", v), 256'(resp), 256'(vecs[v].exp_resp));
        chk($sformatf("v%0d_pulse", v), 256'(pulse), 256'(vecs[v].exp_val[7:0]));
        if (vecs[v].exp_resp == 2'b00) model[vecs[v].addr[4:2]] = vecs[v].data;
        chk($sformatf("v%0d_regs", v), reg_q, model_flat());
      end else begin
        do_read(vecs[v].addr, resp, data);
        chk($sformatf("v%0d_rresp", v), 256'(resp), 256'(vecs[v].exp_resp));
        chk($sformatf("v%0d_rdata", v), 256'(data), 256'(vecs[v].exp_val));
      end
    end

    // Data phase three cycles ahead of the address phase.
    wdata = 32'h12345678; wvalid = 1'b1; bready = 1'b1;
    chk("gotd_wready_idle", 256'(wready), 256'(1));
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("gotd_wready_low", 256'(wready), 256'(0));
      chk("gotd_awready_high", 256'(awready), 256'(1));
      chk("gotd_no_bvalid", 256'(bvalid), 256'(0));
      tick();
    end
    awaddr = 32'h1C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    model[7] = 32'h12345678;
    chk("gotd_bvalid", 256'(bvalid), 256'(1));
    chk("gotd_bresp", 256'(bresp), 256'(0));
    chk("gotd_pulse", 256'(reg_wr_pulse), 256'(8'h80));
    chk("gotd_regs", reg_q, model_flat());
    $display("[TB] split write W-first addr=1c data=12345678 bresp=%b", bresp);
    tick();
    chk("gotd_bvalid_drop", 256'(bvalid), 256'(0));

    // Read and write of register 2 complete on the same edge.
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h08; wdata = 32'h0B; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    model[2] = 32'h0B;
    chk("coll_rvalid", 256'(rvalid), 256'(1));
    chk("coll_rdata_old", 256'(rdata), 256'(32'hA));
    chk("coll_bvalid", 256'(bvalid), 256'(1));
    chk("coll_pulse", 256'(reg_wr_pulse), 256'(8'h04));
    chk("coll_regs", reg_q, model_flat());
    $display("[TB] collide rd/wr addr=08 rdata=%h", rdata);
    tick();
    do_read(32'h08, resp, data);
    chk("coll_reread", 256'(data), 256'(32'h0B));

    // Backpressure on both response channels.
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h0C; wdata = 32'h55; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h04; arvalid = 1'b1;
    tick();
    awaddr = 32'h10; wdata = 32'h99; araddr = 32'h00;
    model[3] = 32'h55;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", 256'({bvalid, bresp}), 256'(3'b100));
      chk("bp_rvalid", 256'({rvalid, rresp}), 256'(3'b100));
      chk("bp_rdata", 256'(rdata), 256'(32'hDEADBEEF));
      chk("bp_readies", 256'({awready, wready, arready}), 256'(0));
      chk("bp_regs", reg_q, model_flat());
      $display("[TB] backpressure cycle %0d bvalid=%b rvalid=%b", i, bvalid, rvalid);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    tick();
    chk("bp_release", 256'({bvalid, rvalid}), 256'(0));
    chk("bp_no_new_write", reg_q, model_flat());

    // Reset while holding a latched write address.
    awaddr = 32'h04; wdata = 32'h77; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("gota_readies", 256'({awready, wready}), 256'(2'b01));
    rst = 1'b1; wvalid = 1'b1;
    tick();
    chk("mid_rst_readies", 256'({awready, wready, arready}), 256'(0));
    chk("mid_rst_valids", 256'({bvalid, rvalid}), 256'(0));
    chk("mid_rst_regs", reg_q, 256'(0));
    chk("mid_rst_pulse", 256'(reg_wr_pulse), 256'(0));
    wvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_rst_readies", 256'({awready, wready, arready}), 256'(3'b111));
    tick(); tick();
    chk("rel_rst_no_bvalid", 256'(bvalid), 256'(0));
    chk("rel_rst_regs", reg_q, 256'(0));
    $display("[TB] reset during W_GOT_A, bvalid=%b", bvalid);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
